ifu_fetch_ctrl: RTL

Fetch request controller on the consumer side of the PC generator. It accepts each next-PC from the PC generator and issues a 16-byte-aligned I-cache request. It tracks up to DEPTH outstanding fetches in order and delivers returned fetch blocks, with a per-slot valid mask, to the fetch buffer. It back-pressures the PC generator through a stall signal and squashes all in-flight fetches on a redirect.

---
 rtl/ifu_fetch_ctrl_pkg.sv | 28 ++
 rtl/ifu_fetchq.sv | 83 ++++++++
 rtl/ifu_fetch_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared fetch-side types and helpers: fetch block geometry, queue entry, slot mask.
`ifndef MXLEN
`define MXLEN 32
`endif

package ifu_fetch_ctrl_pkg;

  localparam int MXLEN       = `MXLEN;
  localparam int FETCH_BYTES = 16;
  localparam int FETCH_SLOTS = 4;
  localparam int SLOT_W      = 32;
  localparam int BLK_W       = FETCH_SLOTS * SLOT_W;

  typedef struct packed {
    logic [MXLEN-1:0] pc;
    logic [BLK_W-1:0] data;
    logic             err;
    logic             data_valid;
  } fetch_entry_t;

  // Slots at or above the starting slot of an unaligned PC carry live instructions.
  function automatic logic [FETCH_SLOTS-1:0] slot_mask(input logic [1:0] first);
    logic [FETCH_SLOTS-1:0] m;
    for (int i = 0; i < FETCH_SLOTS; i++) m[i] = (i >= int'(first));
    return m;
  endfunction

endpackage

// File: rtl/ifu_fetchq.sv
// In-order fetch tracking queue: head (deliver), rsp (next to fill), tail (allocate).
module ifu_fetchq
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [MXLEN-1:0] push_pc_i,
  input  logic             rsp_wr_i,
  input  logic [BLK_W-1:0] rsp_data_i,
  input  logic             rsp_err_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [AW:0]      count_o,
  output logic [AW:0]      pending_o
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]  head_q, head_d, tail_q, tail_d, rsp_q, rsp_d;
  fetch_entry_t ent_q [DEPTH];

  // Extra MSB on each pointer distinguishes full from empty after wrap.
  assign count_o   = tail_q - head_q;
  assign pending_o = tail_q - rsp_q;
  assign head_o    = ent_q[head_q[AW-1:0]];

  // Pointer advance; a flush collapses all three onto the tail.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    rsp_d  = rsp_q;
    if (flush_i) begin
      head_d = tail_q;
      rsp_d  = tail_q;
    end else begin
      if (push_i)   tail_d = tail_q + ONE;
      if (rsp_wr_i) rsp_d  = rsp_q + ONE;
      if (pop_i)    head_d = head_q + ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      rsp_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      rsp_q  <= rsp_d;
    end
  end

  // Entry storage. Push, fill and pop never hit the same slot in one cycle:
  // fill needs a pending entry (not the tail), pop needs filled data (not the
  // rsp slot), and push is blocked when full so it never lands on the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].data_valid <= 1'b0;
    end else begin
      if (push_i) begin
        ent_q[tail_q[AW-1:0]].pc         <= push_pc_i;
        ent_q[tail_q[AW-1:0]].err        <= 1'b0;
        ent_q[tail_q[AW-1:0]].data_valid <= 1'b0;
      end
      if (rsp_wr_i) begin
        ent_q[rsp_q[AW-1:0]].data       <= rsp_data_i;
        ent_q[rsp_q[AW-1:0]].err        <= rsp_err_i;
        ent_q[rsp_q[AW-1:0]].data_valid <= 1'b1;
      end
      if (pop_i) ent_q[head_q[AW-1:0]].data_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch request controller: issues aligned I-cache requests, tracks them in
// order, delivers blocks to the fetch buffer and drops responses after a redirect.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [MXLEN-1:0]       i_pcGen_npc,
  input  logic                   i_pcGen_npc_valid,
  output logic                   o_fetch_pcGen_stall,
  input  logic                   i_flush,
  output logic                   o_icache_req_valid,
  output logic [MXLEN-1:0]       o_icache_req_addr,
  input  logic                   i_icache_req_ready,
  input  logic                   i_icache_rsp_valid,
  input  logic [BLK_W-1:0]       i_icache_rsp_data,
  input  logic                   i_icache_rsp_err,
  output logic                   o_fb_valid,
  output logic [MXLEN-1:0]       o_fb_pc,
  output logic [BLK_W-1:0]       o_fb_data,
  output logic [FETCH_SLOTS-1:0] o_fb_slotMask,
  output logic                   o_fb_err,
  input  logic                   i_fb_ready
);

  localparam int          OFF_W    = $clog2(FETCH_BYTES);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  fetch_entry_t  head;
  logic [AW:0]   q_count, q_pending;
  logic [AW:0]   drop_q, drop_d;
  logic [AW+1:0] occ;
  logic          full, req_fire, rsp_drop, rsp_wr, pop;

  // In-flight = allocated entries plus fetches already squashed but not yet returned.
  assign occ  = {1'b0, q_count} + {1'b0, drop_q};
  assign full = occ >= (AW+2)'(DEPTH);

  // Combinational request path; gated by reset so outputs go quiet immediately.
  assign o_icache_req_valid  = i_rst_n & i_pcGen_npc_valid & ~full & ~i_flush;
  assign o_icache_req_addr   = {i_pcGen_npc[MXLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign o_fetch_pcGen_stall = i_rst_n & i_pcGen_npc_valid & ~i_flush &
                               ~(i_icache_req_ready & ~full);
  assign req_fire            = o_icache_req_valid & i_icache_req_ready;

  // Responses first pay off squashed fetches, then fill the oldest pending entry.
  assign rsp_drop = i_icache_rsp_valid & ~i_flush & (drop_q != '0);
  assign rsp_wr   = i_icache_rsp_valid & ~i_flush & (drop_q == '0) & (q_pending != '0);

  assign o_fb_valid    = head.data_valid & ~i_flush;
  assign o_fb_pc       = head.pc;
  assign o_fb_data     = head.data;
  assign o_fb_err      = head.err;
  assign o_fb_slotMask = head.data_valid ? slot_mask(head.pc[3:2]) : '0;
  assign pop           = o_fb_valid & i_fb_ready;

  ifu_fetchq #(.DEPTH(DEPTH)) u_fetchq (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .push_i     (req_fire),
    .push_pc_i  (i_pcGen_npc),
    .rsp_wr_i   (rsp_wr),
    .rsp_data_i (i_icache_rsp_data),
    .rsp_err_i  (i_icache_rsp_err),
    .pop_i      (pop),
    .flush_i    (i_flush),
    .head_o     (head),
    .count_o    (q_count),
    .pending_o  (q_pending)
  );

  // Drop counter: a flush converts every still-pending fetch into a drop
  // (outstanding drops from an earlier flush are kept); a response arriving in
  // the flush cycle is itself one of them and is consumed on the spot.
  always_comb begin
    drop_d = drop_q;
    if (i_flush) begin
      drop_d = drop_q + q_pending;
      if (i_icache_rsp_valid && drop_d != '0) drop_d = drop_d - ONE;
    end else if (rsp_drop) begin
      drop_d = drop_q - ONE;
    end
  end

  // Drop counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) drop_q <= '0;
    else          drop_q <= drop_d;
  end

  // A response with nothing outstanding means the I-cache broke ordering or was not reset.
  a_rsp_has_owner: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_icache_rsp_valid |-> (q_pending != '0 || drop_q != '0));

endmodule
